regfile_mp: RTL and testbench

//  Parametrised multi-port register file with a busy-bit scoreboard for the pipelined MIPS core.
//  - Read ports: NUM_RD, combinational.
//  - Write ports: NUM_WR, prioritised.
//  - Write-to-read bypass is optional. It replaces the falling-edge write trick.
//  - Sits in decode: feeds operand reads and RAW-hazard detection. Writeback drives the write ports.

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_mp_if.sv | 35 +++
 rtl/regfile_fwd_mux.sv | 63 ++++++
 rtl/regfile_mp.sv | 79 +++++++
 tb/tb_regfile_mp.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// ------------------------------------------------------------------
// regfile_pkg : default sizes, typedefs and write-port priority pick
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;
  localparam int MAX_WR     = 16;

  typedef logic [DEF_ADDR_W-1:0] addr_t;
  typedef logic [DEF_DATA_W-1:0] data_t;

  // Highest set bit wins; returns 0 when nothing is set (caller checks |hit).
  function automatic int wr_sel(input logic [MAX_WR-1:0] hit);
    wr_sel = 0;
    for (int k = 0; k < MAX_WR; k++) begin
      if (hit[k]) wr_sel = k;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_mp_if.sv
// ------------------------------------------------------------------
// regfile_mp_if : write/read/scoreboard bus of the register file
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);

  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] wa;
  logic [NUM_WR*DATA_W-1:0] wd;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic [NUM_RD-1:0]        rbusy;
  logic                     set_busy;
  logic [ADDR_W-1:0]        set_addr;

  modport master (
    output we, wa, wd, ra, set_busy, set_addr,
    input  rd, rbusy
  );

  modport slave (
    input  we, wa, wd, ra, set_busy, set_addr,
    output rd, rbusy
  );

endinterface

`default_nettype wire

// File: rtl/regfile_fwd_mux.sv
// ------------------------------------------------------------------
// regfile_fwd_mux : one read port with write-to-read bypass
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module regfile_fwd_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  wire logic                     reset,
  input  wire logic [ADDR_W-1:0]        ra,
  input  wire logic [NUM_WR-1:0]        we,
  input  wire logic [NUM_WR*ADDR_W-1:0] wa,
  input  wire logic [NUM_WR*DATA_W-1:0] wd,
  input  wire logic [DATA_W-1:0]        stored_data,
  input  wire logic                     stored_busy,
  output logic      [DATA_W-1:0]        rd,
  output logic                          rbusy
);

  logic [NUM_WR-1:0] w_hit;
  logic [MAX_WR-1:0] w_hit_ext;
  logic [DATA_W-1:0] w_wd_sel;
  int                w_sel;

  always_comb begin
    for (int k = 0; k < NUM_WR; k++) begin
      w_hit[k] = BYPASS && !reset && we[k] && (wa[k*ADDR_W +: ADDR_W] == ra);
    end
  end

  assign w_hit_ext = MAX_WR'(w_hit);
  assign w_sel     = wr_sel(w_hit_ext);

  always_comb begin
    w_wd_sel = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (k == w_sel) w_wd_sel = wd[k*DATA_W +: DATA_W];
    end
  end

  // Entry 0 wins over the bypass: a discarded write must never appear.
  always_comb begin
    rd    = stored_data;
    rbusy = stored_busy;
    if (ZERO_REG && (ra == '0)) begin
      rd    = '0;
      rbusy = 1'b0;
    end else if (|w_hit) begin
      rd    = w_wd_sel;
      rbusy = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ------------------------------------------------------------------
// regfile_mp : multi-port register file with busy-bit scoreboard
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input wire logic    clk,
  input wire logic    reset,
  regfile_mp_if.slave bus
);

  localparam int c_depth = 2**ADDR_W;

  logic [DATA_W-1:0]  r_mem [c_depth];
  logic [c_depth-1:0] r_busy;

  // Ascending port loop: the last non-blocking write to an entry wins,
  // giving the higher-index port priority. The set follows the clears so it wins too.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < c_depth; e++) r_mem[e] <= '0;
      r_busy <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.we[k]) begin
          r_busy[bus.wa[k*ADDR_W +: ADDR_W]] <= 1'b0;
          if (!(ZERO_REG && (bus.wa[k*ADDR_W +: ADDR_W] == '0)))
            r_mem[bus.wa[k*ADDR_W +: ADDR_W]] <= bus.wd[k*DATA_W +: DATA_W];
        end
      end
      if (bus.set_busy && !(ZERO_REG && (bus.set_addr == '0)))
        r_busy[bus.set_addr] <= 1'b1;
    end
  end

  generate
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rd;
      logic              w_rbusy;

      assign w_ra = bus.ra[j*ADDR_W +: ADDR_W];

      regfile_fwd_mux #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
      ) u_fwd (
        .reset       (reset),
        .ra          (w_ra),
        .we          (bus.we),
        .wa          (bus.wa),
        .wd          (bus.wd),
        .stored_data (r_mem[w_ra]),
        .stored_busy (r_busy[w_ra]),
        .rd          (w_rd),
        .rbusy       (w_rbusy)
      );

      assign bus.rd[j*DATA_W +: DATA_W] = w_rd;
      assign bus.rbusy[j]               = w_rbusy;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ------------------------------------------------------------------
// tb_regfile_mp : scoreboard bench for regfile_mp (default parameters)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_regfile_mp;
  import regfile_pkg::*;

  typedef struct {
    logic       rst;
    logic [1:0] we;
    logic [4:0] wa0, wa1, ra0, ra1, sa;
    data_t      wd0, wd1;
    logic       sb;
    logic       chk;
  } stim_t;

  typedef struct packed {
    logic [1:0][31:0] rd;
    logic [1:0]       rb;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus ();

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  data_t m_mem  [32];
  logic  m_busy [32];
  exp_t  q [$];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic stim_t mk(input logic rst, input logic [1:0] we,
                               input logic [4:0] wa0, input data_t wd0,
                               input logic [4:0] wa1, input data_t wd1,
                               input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic sb, input logic [4:0] sa);
    stim_t s;
    s.rst = rst; s.we = we; s.wa0 = wa0; s.wd0 = wd0; s.wa1 = wa1; s.wd1 = wd1;
    s.ra0 = ra0; s.ra1 = ra1; s.sb = sb; s.sa = sa; s.chk = 1'b1;
    return s;
  endfunction

  // Expected reads come from the pre-edge model; the model then advances to post-edge state.
  task automatic drive(input stim_t s);
    exp_t       e;
    logic [4:0] ras [2];
    logic [4:0] was [2];
    data_t      wds [2];
    @(negedge clk);
    reset        = s.rst;
    bus.we       = s.we;
    bus.wa       = {s.wa1, s.wa0};
    bus.wd       = {s.wd1, s.wd0};
    bus.ra       = {s.ra1, s.ra0};
    bus.set_busy = s.sb;
    bus.set_addr = s.sa;
    ras[0] = s.ra0; ras[1] = s.ra1;
    was[0] = s.wa0; was[1] = s.wa1;
    wds[0] = s.wd0; wds[1] = s.wd1;
    for (int j = 0; j < 2; j++) begin
      if (ras[j] == 5'd0) begin
        e.rd[j] = 32'd0;
        e.rb[j] = 1'b0;
      end else begin
        e.rd[j] = m_mem[ras[j]];
        e.rb[j] = m_busy[ras[j]];
        if (!s.rst) begin
          for (int k = 0; k < 2; k++) begin
            if (s.we[k] && was[k] == ras[j]) begin
              e.rd[j] = wds[k];
              e.rb[j] = 1'b0;
            end
          end
        end
      end
    end
    if (s.chk) q.push_back(e);
    if (s.rst) begin
      for (int a = 0; a < 32; a++) begin
        m_mem[a]  = 32'd0;
        m_busy[a] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (s.we[k]) begin
          m_busy[was[k]] = 1'b0;
          if (was[k] != 5'd0) m_mem[was[k]] = wds[k];
        end
      end
      if (s.sb && s.sa != 5'd0) m_busy[s.sa] = 1'b1;
    end
  endtask

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  // Monitor: reads are combinational, so every driven cycle presents a response.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int j = 0; j < 2; j++) begin
          n_checks++;
          if (bus.rd[j*32 +: 32] !== e.rd[j]) begin
            n_fail++;
            $display("FAIL rd%0d ra=%0d: got %h expected %h at %0t",
                     j, bus.ra[j*5 +: 5], bus.rd[j*32 +: 32], e.rd[j], $time);
          end
          n_checks++;
          if (bus.rbusy[j] !== e.rb[j]) begin
            n_fail++;
            $display("FAIL rbusy%0d ra=%0d: got %b expected %b at %0t",
                     j, bus.ra[j*5 +: 5], bus.rbusy[j], e.rb[j], $time);
          end
        end
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    reset = 1'b1;
    bus.we = '0; bus.wa = '0; bus.wd = '0; bus.ra = '0;
    bus.set_busy = 1'b0; bus.set_addr = '0;
    for (int a = 0; a < 32; a++) begin
      m_mem[a] = 32'd0;
      m_busy[a] = 1'b0;
    end

    s = mk(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    s.chk = 1'b0;
    drive(s);

    // Every address after reset
    for (int i = 0; i < 16; i++)
      drive(mk(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'(2*i), 5'(2*i+1), 1'b0, 5'd0));

    // Same-cycle bypass, then stored value
    drive(mk(1'b0, 2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0, 5'd5, 5'd6, 1'b0, 5'd0));
    drive(mk(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0, 5'd0));

    // Colliding writes: port 1 wins
    drive(mk(1'b0, 2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222, 5'd7, 5'd7, 1'b0, 5'd0));
    drive(mk(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 5'd5, 1'b0, 5'd0));

    // Entry 0 ignores writes and busy sets
    drive(mk(1'b0, 2'b10, 5'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, 5'd0));
    drive(mk(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0));

    // Busy set / clear / set-wins
    drive(mk(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b1, 5'd9));
    drive(mk(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b0, 5'd0));
    drive(mk(1'b0, 2'b01, 5'd9, 32'h99, 5'd0, 32'd0, 5'd9, 5'd9, 1'b0, 5'd0));
    drive(mk(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b0, 5'd0));
    drive(mk(1'b0, 2'b01, 5'd9, 32'h98, 5'd0, 32'd0, 5'd9, 5'd9, 1'b1, 5'd9));
    drive(mk(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b0, 5'd0));

    // Reset mid-operation drops the pending write
    drive(mk(1'b0, 2'b01, 5'd3, 32'hA5A5, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1, 5'd4));
    drive(mk(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b0, 5'd0));
    drive(mk(1'b1, 2'b01, 5'd3, 32'h1, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1, 5'd4));
    drive(mk(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b0, 5'd0));

    for (int n = 0; n < 400; n++) begin
      s.rst = ($urandom_range(0, 49) == 0);
      s.we  = 2'($urandom_range(0, 3));
      s.wa0 = rnd_addr();
      s.wa1 = ($urandom_range(0, 3) == 0) ? s.wa0 : rnd_addr();
      s.wd0 = $urandom;
      s.wd1 = $urandom;
      s.ra0 = ($urandom_range(0, 2) == 0) ? s.wa0 : rnd_addr();
      s.ra1 = ($urandom_range(0, 2) == 0) ? s.wa1 : rnd_addr();
      s.sb  = $urandom_range(0, 1) != 0;
      s.sa  = ($urandom_range(0, 3) == 0) ? s.wa0 : rnd_addr();
      s.chk = 1'b1;
      drive(s);
    end

    repeat (3) @(negedge clk);
    #5;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
